// File: rtl/iqdemod.sv
// rtl/iqdemod.sv - quadrature demodulator: sincos mixer, integrate-and-dump, sat8 decimated I/Q
module iqdemod #(
  parameter int POSPERCLK  = 8,
  parameter int DECIM_LOG2 = 5
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              en,
  input  logic              sync,
  input  logic [9:0]        adcval,
  output logic signed [7:0] i_out,
  output logic signed [7:0] q_out,
  output logic              out_valid
);

  localparam int AW = 20 + DECIM_LOG2;
  localparam int SH = DECIM_LOG2 + 7;

  typedef enum logic [1:0] {IDLE, ACC, DUMP} state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [7:0]              tpos;
  logic [DECIM_LOG2-1:0]   cnt;
  logic signed [AW-1:0]    acc_i;
  logic signed [AW-1:0]    acc_q;

  logic [7:0]              sin_u;
  logic [7:0]              cos_u;
  logic signed [10:0]      x;
  logic signed [8:0]       c;
  logic signed [8:0]       s;
  logic signed [19:0]      pi;
  logic signed [19:0]      pq;
  logic signed [AW-1:0]    sum_i;
  logic signed [AW-1:0]    sum_q;
  logic signed [AW-1:0]    sh_i;
  logic signed [AW-1:0]    sh_q;
  logic                    take;
  logic                    last;

  // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64.
  function automatic logic [6:0] quarter(input logic [6:0] k);
    case (k)
      7'd0:  quarter = 7'd0;
      7'd1:  quarter = 7'd3;
      7'd2:  quarter = 7'd6;
      7'd3:  quarter = 7'd9;
      7'd4:  quarter = 7'd12;
      7'd5:  quarter = 7'd16;
      7'd6:  quarter = 7'd19;
      7'd7:  quarter = 7'd22;
      7'd8:  quarter = 7'd25;
      7'd9:  quarter = 7'd28;
      7'd10: quarter = 7'd31;
      7'd11: quarter = 7'd34;
      7'd12: quarter = 7'd37;
      7'd13: quarter = 7'd40;
      7'd14: quarter = 7'd43;
      7'd15: quarter = 7'd46;
      7'd16: quarter = 7'd49;
      7'd17: quarter = 7'd51;
      7'd18: quarter = 7'd54;
      7'd19: quarter = 7'd57;
      7'd20: quarter = 7'd60;
      7'd21: quarter = 7'd63;
      7'd22: quarter = 7'd65;
      7'd23: quarter = 7'd68;
      7'd24: quarter = 7'd71;
      7'd25: quarter = 7'd73;
      7'd26: quarter = 7'd76;
      7'd27: quarter = 7'd78;
      7'd28: quarter = 7'd81;
      7'd29: quarter = 7'd83;
      7'd30: quarter = 7'd85;
      7'd31: quarter = 7'd88;
      7'd32: quarter = 7'd90;
      7'd33: quarter = 7'd92;
      7'd34: quarter = 7'd94;
      7'd35: quarter = 7'd96;
      7'd36: quarter = 7'd98;
      7'd37: quarter = 7'd100;
      7'd38: quarter = 7'd102;
      7'd39: quarter = 7'd104;
      7'd40: quarter = 7'd106;
      7'd41: quarter = 7'd107;
      7'd42: quarter = 7'd109;
      7'd43: quarter = 7'd111;
      7'd44: quarter = 7'd112;
      7'd45: quarter = 7'd113;
      7'd46: quarter = 7'd115;
      7'd47: quarter = 7'd116;
      7'd48: quarter = 7'd117;
      7'd49: quarter = 7'd118;
      7'd50: quarter = 7'd120;
      7'd51: quarter = 7'd121;
      7'd52: quarter = 7'd122;
      7'd53: quarter = 7'd122;
      7'd54: quarter = 7'd123;
      7'd55: quarter = 7'd124;
      7'd56: quarter = 7'd125;
      7'd57: quarter = 7'd125;
      7'd58: quarter = 7'd126;
      7'd59: quarter = 7'd126;
      7'd60: quarter = 7'd126;
      default: quarter = 7'd127;
    endcase
  endfunction

  function automatic logic [7:0] sine_lut(input logic [7:0] p);
    logic [6:0] idx;
    logic [6:0] mag;
    idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
    mag = quarter(idx);
    sine_lut = p[7] ? (8'd128 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
  endfunction

  function automatic logic [7:0] sat8(input logic signed [AW-1:0] v);
    if (v[AW-1:7] == '0 || v[AW-1:7] == '1) sat8 = v[7:0];
    else                                    sat8 = v[AW-1] ? 8'h80 : 8'h7f;
  endfunction

  assign sin_u = sine_lut(tpos);
  assign cos_u = sine_lut(tpos + 8'd64);

  // Offset-binary to two's complement is just an inverted MSB.
  assign x  = {~adcval[9], ~adcval[9], adcval[8:0]};
  assign c  = {~cos_u[7], ~cos_u[7], cos_u[6:0]};
  assign s  = {~sin_u[7], ~sin_u[7], sin_u[6:0]};
  assign pi = x * c;
  assign pq = -(x * s);

  assign sum_i = acc_i + {{(AW-20){pi[19]}}, pi};
  assign sum_q = acc_q + {{(AW-20){pq[19]}}, pq};
  assign sh_i  = sum_i >>> SH;
  assign sh_q  = sum_q >>> SH;

  assign take = en && !sync;
  assign last = (cnt == '1);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (sync)                state_nx = IDLE;
    else if (en)             state_nx = last ? DUMP : ACC;
    else if (state == DUMP)  state_nx = IDLE;
  end

  always_comb begin
    out_valid = (state == DUMP);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      tpos  <= '0;
      cnt   <= '0;
      acc_i <= '0;
      acc_q <= '0;
      i_out <= '0;
      q_out <= '0;
    end else if (sync) begin
      tpos  <= '0;
      cnt   <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (take) begin
      tpos <= tpos + 8'(POSPERCLK);
      cnt  <= cnt + 1'b1;
      if (last) begin
        acc_i <= '0;
        acc_q <= '0;
        i_out <= sat8(sh_i);
        q_out <= sat8(sh_q);
      end else begin
        acc_i <= sum_i;
        acc_q <= sum_q;
      end
    end
  end

endmodule

// File: doc/iqdemod.md
Name: iqdemod

Overview:
- Quadrature demodulator; the receive-side counterpart of the iqmod transmit path.
- Takes 10-bit offset-binary ADC samples and mixes them against the team's 8-bit sincos lookup, driven by an internal phase counter.
- Integrates and dumps over 2^DECIM_LOG2 samples and emits decimated signed 8-bit I/Q with a one-cycle valid strobe.
- Scaling is chosen so a loopback of iqmod output recovers the original i/q to within a few LSB.

Parameters:
POSPERCLK, 8, phase increment per accepted sample; carrier = POSPERCLK*fs/256
DECIM_LOG2, 5, log2 of samples per dump (N = 2^DECIM_LOG2); N*POSPERCLK must be a multiple of 256 (whole carrier periods)

Ports:
clk  input  1  sample clock; all logic on rising edge
reset_  input  1  asynchronous, active-low reset
en  input  1  sample accepted on rising edge when high
sync  input  1  synchronous phase/block restart; has priority over en
adcval  input  10  unsigned ADC sample, midscale 512
i_out  output  8  signed recovered in-phase value, held between dumps
q_out  output  8  signed recovered quadrature value, held between dumps
out_valid  output  1  one-cycle strobe, high in the cycle after a dump

Behaviour:
- Reset (async, reset_=0): tpos=0, acc_i=acc_q=0, cnt=0, i_out=q_out=0, out_valid=0, state=IDLE.
- sincos is combinational: sin and cos are both addressed by tpos; outputs are unsigned 0..255, offset 128.
- Arithmetic per accepted sample:
  - x = adcval - 512 (signed 11-bit)
  - c = cos - 128, s = sin - 128 (signed 9-bit)
  - pi = x*c, pq = -(x*s), each signed 20-bit
  - acc_i and acc_q are signed, 20+DECIM_LOG2 bits wide; they never overflow.
- FSM states:
  - IDLE: entered from reset. Moves to ACC on the first rising edge with en=1, and that sample is accumulated on the same edge.
  - ACC: accumulating samples.
  - DUMP: single cycle, out_valid=1. Returns to ACC if en=1 on that edge, else to IDLE. In both cases the sample on that edge is accumulated when en=1.
- Each edge with en=1 and sync=0: acc += product, tpos += POSPERCLK (mod 256), cnt += 1.
- Dump (edge when cnt == N-1 and en=1):
  - i_out <= sat8((acc_i + pi) >>> (DECIM_LOG2+7)); same for q_out.
  - acc <= 0, cnt <= 0, next state DUMP.
- sat8 clamps to [-128, 127]. The shift is arithmetic (floor toward -inf).
- en=0 (not sync): tpos, acc, cnt and i_out/q_out all hold, and out_valid goes to 0. A block interrupted by en=0 produces the same result as an uninterrupted one.
- sync=1 (any state, regardless of en):
  - tpos=0, acc=0, cnt=0, out_valid=0, state=IDLE.
  - i_out/q_out hold.
  - The sample on that edge is discarded.
- Latency: out_valid asserts on the edge that accepts the N-th sample of the block, i.e. it is visible the cycle after that sample is presented. i_out/q_out update on the same edge.
- Back-to-back dumps occur every N accepted samples. out_valid is never high for two consecutive cycles unless N=1 (not supported; DECIM_LOG2 >= 1).
- Async reset mid-block discards the partial block; the first valid after release needs N fresh samples.

Test Plan:
1. Hold reset_=0 while driving adcval=1023, en=1 -> i_out=0, q_out=0, out_valid=0, tpos=0 throughout. Release -> first out_valid exactly after 32 accepted samples.
2. adcval=512 constant, en=1, 64 cycles -> two out_valid pulses 32 cycles apart, each with i_out=0 and q_out=0.
3. Loopback: the bench drives adcval = (64*(cos[tpos]-128))/64 + 512 with phase aligned via sync. Also check the quadrature case.
   - Expected: every dump gives i_out in [62,64], q_out in [-1,1].
   - With the q=64 stimulus (-(64*(sin-128))/64 + 512): q_out in [62,64], i_out in [-1,1].
4. Saturation: adcval=1023 when cos[tpos]>=128 else 0 -> i_out=127 (clamped), and no wrap to negative.
5. Interruption:
   - After 10 samples, drop en for 5 cycles -> out_valid arrives 5 cycles late with values identical to the uninterrupted run.
   - After 10 samples, pulse sync -> no out_valid until 32 samples after sync, and i_out/q_out keep their previous values until then.
6. Async reset asserted mid-block (cnt=20), asynchronously between edges -> all outputs go to 0 immediately. After release, next out_valid only after 32 accepted samples.
